sprite_compositor: RTL and testbench

Parametrised pixel compositor for the VGA path: priority-merges NUM_SPRITES rectangular sprites over a background, with per-sprite colour-key transparency, and selects full-screen sources per game screen. It sits between the sprite/background ROM readers and the VGA output pins. It adds three things to the combinational colour mapper:
- a two-stage registered pipeline;
- frame-synchronous screen switching, so the screen never tears;
- per-frame sprite collision reporting.

---
 rtl/sprite_compositor.sv | 155 +++++++++++++++
 tb/tb_sprite_compositor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: priority-merges sprites over a background,
// switches full-screen sources only at frame start, and reports per-frame collisions.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 4,
    parameter int NUM_KEYS    = 2
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               blank,
    input  logic [COORD_W-1:0]                 DrawX,
    input  logic [COORD_W-1:0]                 DrawY,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_y,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_w,
    input  logic [NUM_SPRITES*COORD_W-1:0]     spr_h,
    input  logic [NUM_SPRITES-1:0]             spr_en,
    input  logic [NUM_SPRITES-1:0]             spr_key_en,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0]   spr_rgb,
    input  logic [NUM_KEYS*3*COLOR_W-1:0]      key_rgb,
    input  logic [3*COLOR_W-1:0]               bg_rgb,
    input  logic [3*3*COLOR_W-1:0]             fs_rgb,
    input  logic [1:0]                         screen_mode,
    output logic [1:0]                         active_mode,
    output logic [COLOR_W-1:0]                 Red,
    output logic [COLOR_W-1:0]                 Green,
    output logic [COLOR_W-1:0]                 Blue,
    output logic [NUM_SPRITES-1:0]             collision,
    output logic                               frame_done
);
    localparam int RGB_W = 3 * COLOR_W;

    // Zero-extended difference keeps sprites past the right/bottom edge clipped, never wrapped.
    function automatic logic axis_hit(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] org,
                                      input logic [COORD_W-1:0] size);
        logic [COORD_W:0] diff;
        diff = {1'b0, pos} - {1'b0, org};
        return (pos >= org) && (diff < {1'b0, size});
    endfunction

    function automatic logic key_match(input logic [RGB_W-1:0] rgb,
                                       input logic [NUM_KEYS*RGB_W-1:0] keys);
        logic m;
        m = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (rgb == keys[k*RGB_W +: RGB_W]) m = 1'b1;
        return m;
    endfunction

    logic                         fs;
    logic [1:0]                   mode_cur;
    logic [NUM_SPRITES-1:0]       opaque;
    logic [RGB_W-1:0]             fs_sel;

    // The frame-start pixel is already drawn in the newly requested mode.
    assign fs       = (DrawX == '0) && (DrawY == '0);
    assign mode_cur = fs ? screen_mode : active_mode;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = spr_en[i]
                && axis_hit(DrawX, spr_x[i*COORD_W +: COORD_W], spr_w[i*COORD_W +: COORD_W])
                && axis_hit(DrawY, spr_y[i*COORD_W +: COORD_W], spr_h[i*COORD_W +: COORD_W])
                && !(spr_key_en[i] && key_match(spr_rgb[i*RGB_W +: RGB_W], key_rgb));
        end
    end

    always_comb begin
        case (mode_cur)
            2'b10:   fs_sel = fs_rgb[1*RGB_W +: RGB_W];
            2'b11:   fs_sel = fs_rgb[2*RGB_W +: RGB_W];
            default: fs_sel = fs_rgb[0 +: RGB_W];
        endcase
    end

    // ---- stage 1 boundary ----
    logic [NUM_SPRITES-1:0]       opaque_p1;
    logic [NUM_SPRITES*RGB_W-1:0] spr_rgb_p1;
    logic [RGB_W-1:0]             bg_p1;
    logic [RGB_W-1:0]             fs_sel_p1;
    logic                         blank_p1;
    logic [1:0]                   mode_p1;
    logic                         fs_p1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            active_mode <= 2'b00;
            opaque_p1   <= '0;
            spr_rgb_p1  <= '0;
            bg_p1       <= '0;
            fs_sel_p1   <= '0;
            blank_p1    <= 1'b0;
            mode_p1     <= 2'b00;
            fs_p1       <= 1'b0;
        end else begin
            active_mode <= mode_cur;
            opaque_p1   <= opaque;
            spr_rgb_p1  <= spr_rgb;
            bg_p1       <= bg_rgb;
            fs_sel_p1   <= fs_sel;
            blank_p1    <= blank;
            mode_p1     <= mode_cur;
            fs_p1       <= fs;
        end
    end

    logic [RGB_W-1:0]       pix;
    logic                   multi_hit;
    logic [NUM_SPRITES-1:0] contrib;

    always_comb begin
        pix = bg_p1;
        if (!blank_p1) begin
            pix = '0;
        end else if (mode_p1 != 2'b01) begin
            pix = fs_sel_p1;
        end else begin
            for (int i = NUM_SPRITES - 1; i >= 0; i--)
                if (opaque_p1[i]) pix = spr_rgb_p1[i*RGB_W +: RGB_W];
        end
    end

    // Clearing the lowest set bit leaves something only when two or more sprites overlap.
    assign multi_hit = |(opaque_p1 & (opaque_p1 - NUM_SPRITES'(1)));
    assign contrib   = (blank_p1 && (mode_p1 == 2'b01) && multi_hit) ? opaque_p1 : '0;

    // ---- stage 2 boundary ----
    logic [RGB_W-1:0]       pix_p2;
    logic [NUM_SPRITES-1:0] acc_p2;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pix_p2     <= '0;
            acc_p2     <= '0;
            collision  <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_p2     <= pix;
            frame_done <= fs_p1;
            if (fs_p1) begin
                collision <= acc_p2;
                acc_p2    <= contrib;
            end else begin
                acc_p2    <= acc_p2 | contrib;
            end
        end
    end

    assign Red   = pix_p2[2*COLOR_W +: COLOR_W];
    assign Green = pix_p2[1*COLOR_W +: COLOR_W];
    assign Blue  = pix_p2[0 +: COLOR_W];
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table of pixel vectors plus hand sequences,
// expected results queued at drive time and compared two cycles later.
module tb_sprite_compositor;
    localparam int N = 4, CW = 10, C = 4, K = 2, RGB = 12;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              blank;
    logic [CW-1:0]     DrawX, DrawY;
    logic [N*CW-1:0]   spr_x, spr_y, spr_w, spr_h;
    logic [N-1:0]      spr_en, spr_key_en;
    logic [N*RGB-1:0]  spr_rgb;
    logic [K*RGB-1:0]  key_rgb;
    logic [RGB-1:0]    bg_rgb;
    logic [3*RGB-1:0]  fs_rgb;
    logic [1:0]        screen_mode, active_mode;
    logic [C-1:0]      Red, Green, Blue;
    logic [N-1:0]      collision;
    logic              frame_done;

    sprite_compositor #(.NUM_SPRITES(N), .COORD_W(CW), .COLOR_W(C), .NUM_KEYS(K)) dut (
        .Clk(Clk), .Reset(Reset), .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
        .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
        .spr_en(spr_en), .spr_key_en(spr_key_en), .spr_rgb(spr_rgb),
        .key_rgb(key_rgb), .bg_rgb(bg_rgb), .fs_rgb(fs_rgb),
        .screen_mode(screen_mode), .active_mode(active_mode),
        .Red(Red), .Green(Green), .Blue(Blue),
        .collision(collision), .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [CW-1:0] x, y;
        bit            chk_rgb;
        logic [11:0]   rgb;
        bit            chk_coll;
        logic [3:0]    coll;
        logic          fd;
    } exp_t;

    typedef struct {
        logic [CW-1:0] x, y;
        logic          b;
        logic [11:0]   rgb;
    } vec_t;

    exp_t q[$];
    vec_t tbl[14];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_spr(input int i, input logic [CW-1:0] x, y, w, h,
                           input logic en, key, input logic [11:0] rgb);
        spr_x[i*CW +: CW]    = x;
        spr_y[i*CW +: CW]    = y;
        spr_w[i*CW +: CW]    = w;
        spr_h[i*CW +: CW]    = h;
        spr_en[i]            = en;
        spr_key_en[i]        = key;
        spr_rgb[i*RGB +: RGB] = rgb;
    endtask

    // Drive one pixel, queue its expectation, then compare the pixel from the previous cycle.
    task automatic step(input logic [CW-1:0] x, y, input logic b,
                        input bit chk_rgb, input logic [11:0] rgb,
                        input bit chk_coll, input logic [3:0] coll, input logic fd);
        exp_t e;
        DrawX = x; DrawY = y; blank = b;
        e.x = x; e.y = y; e.chk_rgb = chk_rgb; e.rgb = rgb;
        e.chk_coll = chk_coll; e.coll = coll; e.fd = fd;
        q.push_back(e);
        @(posedge Clk); #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            if (e.chk_rgb)
                check($sformatf("rgb(%0d,%0d)", e.x, e.y), {20'd0, Red, Green, Blue}, {20'd0, e.rgb});
            if (e.chk_coll) begin
                check($sformatf("collision(%0d,%0d)", e.x, e.y), {28'd0, collision}, {28'd0, e.coll});
                check($sformatf("frame_done(%0d,%0d)", e.x, e.y), {31'd0, frame_done}, {31'd0, e.fd});
            end
        end
    endtask

    task automatic pix(input logic [CW-1:0] x, y, input logic [11:0] rgb);
        step(x, y, 1'b1, 1'b1, rgb, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic pix_c(input logic [CW-1:0] x, y, input logic b, input logic [11:0] rgb,
                         input logic [3:0] coll, input logic fd);
        step(x, y, b, 1'b1, rgb, 1'b1, coll, fd);
    endtask

    task automatic restart_queue();
        exp_t e;
        q.delete();
        e.x = '0; e.y = '0; e.chk_rgb = 1'b1; e.rgb = 12'h000;
        e.chk_coll = 1'b1; e.coll = 4'h0; e.fd = 1'b0;
        q.push_back(e);
    endtask

    initial begin
        tbl[0]  = '{10'd9,  10'd10, 1'b1, 12'hABC};
        tbl[1]  = '{10'd10, 10'd10, 1'b1, 12'hF00};
        tbl[2]  = '{10'd11, 10'd10, 1'b1, 12'hF00};
        tbl[3]  = '{10'd12, 10'd10, 1'b1, 12'hF00};
        tbl[4]  = '{10'd13, 10'd10, 1'b1, 12'hF00};
        tbl[5]  = '{10'd14, 10'd10, 1'b1, 12'h0F0};
        tbl[6]  = '{10'd15, 10'd10, 1'b1, 12'h0F0};
        tbl[7]  = '{10'd16, 10'd10, 1'b1, 12'hABC};
        tbl[8]  = '{10'd10, 10'd9,  1'b1, 12'hABC};
        tbl[9]  = '{10'd10, 10'd13, 1'b1, 12'hF00};
        tbl[10] = '{10'd10, 10'd14, 1'b1, 12'hABC};
        tbl[11] = '{10'd14, 10'd13, 1'b1, 12'h0F0};
        tbl[12] = '{10'd12, 10'd11, 1'b0, 12'h000};
        tbl[13] = '{10'd15, 10'd14, 1'b1, 12'hABC};

        Reset = 1'b0; blank = 1'b0; DrawX = 10'd500; DrawY = 10'd500;
        spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0;
        spr_en = '0; spr_key_en = '0; spr_rgb = '0;
        key_rgb = {12'h246, 12'hFFF};
        bg_rgb = 12'hABC;
        fs_rgb = {12'hC3C, 12'h5A5, 12'h123};
        screen_mode = 2'b01;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("reset_rgb", {20'd0, Red, Green, Blue}, 32'h0);
        check("reset_collision", {28'd0, collision}, 32'h0);
        check("reset_frame_done", {31'd0, frame_done}, 32'h0);
        check("reset_active_mode", {30'd0, active_mode}, 32'h0);
        Reset = 1'b1;
        restart_queue();

        // Post-reset stream starting at frame start
        pix(10'd0, 10'd0, 12'hABC);
        check("active_after_fs", {30'd0, active_mode}, 32'h1);
        pix(10'd1, 10'd0, 12'hABC);
        pix(10'd2, 10'd0, 12'hABC);
        pix(10'd3, 10'd0, 12'hABC);

        // Priority table
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'hF00);
        set_spr(1, 10'd12, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'h0F0);
        for (int i = 0; i < 14; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].b, 1'b1, tbl[i].rgb, 1'b0, 4'h0, 1'b0);

        // Colour keys
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b1, 12'hFFF);
        set_spr(1, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'h0F0);
        pix(10'd11, 10'd11, 12'h0F0);
        spr_key_en[0] = 1'b0;
        pix(10'd11, 10'd11, 12'hFFF);
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b1, 12'h246);
        pix(10'd12, 10'd11, 12'h0F0);
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b1, 12'hF00);
        pix(10'd12, 10'd11, 12'hF00);

        // Mode switch waits for frame start
        screen_mode = 2'b10;
        pix(10'd100, 10'd50, 12'hABC);
        pix(10'd101, 10'd50, 12'hABC);
        check("active_before_fs", {30'd0, active_mode}, 32'h1);
        pix(10'd0, 10'd0, 12'h5A5);
        check("active_mode_10", {30'd0, active_mode}, 32'h2);
        screen_mode = 2'b01;
        pix(10'd1, 10'd0, 12'h5A5);
        pix(10'd11, 10'd11, 12'h5A5);
        check("active_hold_10", {30'd0, active_mode}, 32'h2);
        screen_mode = 2'b11;
        pix(10'd0, 10'd0, 12'hC3C);
        check("active_mode_11", {30'd0, active_mode}, 32'h3);
        step(10'd5, 10'd0, 1'b0, 1'b1, 12'h000, 1'b0, 4'h0, 1'b0);
        screen_mode = 2'b00;
        pix(10'd0, 10'd0, 12'h123);
        screen_mode = 2'b01;
        pix(10'd0, 10'd0, 12'hABC);

        // Collisions
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'hF00);
        set_spr(1, 10'd0,  10'd0,  10'd4, 10'd4, 1'b0, 1'b0, 12'h0F0);
        set_spr(2, 10'd12, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'h00F);
        pix(10'd0, 10'd0, 12'hABC);
        pix(10'd12, 10'd10, 12'hF00);
        pix(10'd20, 10'd20, 12'hABC);
        pix_c(10'd0, 10'd0, 1'b1, 12'hABC, 4'b0101, 1'b1);
        pix_c(10'd12, 10'd10, 1'b0, 12'h000, 4'b0101, 1'b0);
        pix(10'd30, 10'd30, 12'hABC);
        set_spr(0, 10'd0, 10'd0, 10'd4, 10'd4, 1'b1, 1'b0, 12'hF00);
        set_spr(2, 10'd0, 10'd0, 10'd4, 10'd4, 1'b1, 1'b0, 12'h00F);
        pix_c(10'd0, 10'd0, 1'b1, 12'hF00, 4'b0000, 1'b1);
        set_spr(0, 10'd10, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'hF00);
        set_spr(2, 10'd12, 10'd10, 10'd4, 10'd4, 1'b1, 1'b0, 12'h00F);
        pix(10'd40, 10'd40, 12'hABC);
        pix_c(10'd0, 10'd0, 1'b1, 12'hABC, 4'b0101, 1'b1);
        set_spr(1, 10'd10, 10'd10, 10'd0, 10'd4, 1'b1, 1'b0, 12'h0F0);
        spr_en[2] = 1'b0;
        pix(10'd10, 10'd10, 12'hF00);
        pix_c(10'd0, 10'd0, 1'b1, 12'hABC, 4'b0000, 1'b1);

        // Right-edge clipping
        spr_en = '0;
        set_spr(3, 10'd1020, 10'd10, 10'd10, 10'd4, 1'b1, 1'b0, 12'h0FF);
        pix(10'd1019, 10'd10, 12'hABC);
        pix(10'd1020, 10'd10, 12'h0FF);
        pix(10'd1023, 10'd10, 12'h0FF);
        pix(10'd0, 10'd10, 12'hABC);
        pix(10'd5, 10'd10, 12'hABC);
        pix(10'd1021, 10'd13, 12'h0FF);
        pix(10'd1021, 10'd14, 12'hABC);

        // Reset mid-frame
        pix(10'd200, 10'd200, 12'hABC);
        #2 Reset = 1'b0;
        #1;
        check("midreset_rgb", {20'd0, Red, Green, Blue}, 32'h0);
        check("midreset_active", {30'd0, active_mode}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        restart_queue();
        pix(10'd5, 10'd5, 12'h123);
        pix(10'd6, 10'd6, 12'h123);
        check("active_after_reset", {30'd0, active_mode}, 32'h0);
        pix(10'd0, 10'd0, 12'hABC);
        check("active_reset_fs", {30'd0, active_mode}, 32'h1);
        step(10'd500, 10'd500, 1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
